// File: rtl/segre_mem_arbiter.sv
// Main-memory port arbiter for D$ refills, I$ refills and store write-through.
// Define SEGRE_MEM_ARB_RR_EN for round-robin grant; default is fixed DC > WR > IC.
module segre_mem_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int LANE_SIZE = 128
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 dc_miss_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    output logic                 dc_data_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,
    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_data_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,
    input  logic                 wr_req_i,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    output logic                 wr_ack_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wr_data_o,
    input  logic                 mem_ack_i,
    input  logic [LANE_SIZE-1:0] mem_data_i,
    output logic                 busy_o
);

    localparam int OFF = $clog2(LANE_SIZE / 8);

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_READ  = 2'd1;
    localparam logic [1:0] ARB_WRITE = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic [1:0] ID_DC = 2'd0;
    localparam logic [1:0] ID_WR = 2'd1;
    localparam logic [1:0] ID_IC = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 mem_rd_q, mem_rd_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 dc_rdy_q, dc_rdy_d;
    logic                 ic_rdy_q, ic_rdy_d;
    logic                 wr_ack_q, wr_ack_d;
    logic [LANE_SIZE-1:0] dc_data_q, dc_data_d;
    logic [LANE_SIZE-1:0] ic_data_q, ic_data_d;
    logic                 busy_q, busy_d;

    logic                 req_any;
    logic                 same_lane;
    logic [1:0]           gnt_id;
    logic [ADDR_SIZE-1:0] dc_lane_addr;
    logic [ADDR_SIZE-1:0] ic_lane_addr;

    assign req_any = dc_miss_i | ic_miss_i | wr_req_i;

    // A pending store to the missing lane must reach memory before the refill.
    assign same_lane = dc_miss_i & wr_req_i &
        (dc_addr_i[ADDR_SIZE-1:OFF] == wr_addr_i[ADDR_SIZE-1:OFF]);

    assign dc_lane_addr = {dc_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
    assign ic_lane_addr = {ic_addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};

`ifdef SEGRE_MEM_ARB_RR_EN
    logic [1:0] rr_q, rr_d;

    always_comb begin
        gnt_id = ID_DC;
        if (same_lane) begin
            gnt_id = ID_WR;
        end else begin
            case (rr_q)
                ID_WR: begin
                    if (wr_req_i)       gnt_id = ID_WR;
                    else if (ic_miss_i) gnt_id = ID_IC;
                    else                gnt_id = ID_DC;
                end
                ID_IC: begin
                    if (ic_miss_i)      gnt_id = ID_IC;
                    else if (dc_miss_i) gnt_id = ID_DC;
                    else                gnt_id = ID_WR;
                end
                default: begin
                    if (dc_miss_i)      gnt_id = ID_DC;
                    else if (wr_req_i)  gnt_id = ID_WR;
                    else                gnt_id = ID_IC;
                end
            endcase
        end
    end

    // The granted requester drops to lowest priority.
    always_comb begin
        rr_d = rr_q;
        if (state_q == ARB_IDLE && req_any) begin
            unique case (1'b1)
                gnt_id == ID_DC: rr_d = ID_WR;
                gnt_id == ID_WR: rr_d = ID_IC;
                default:         rr_d = ID_DC;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) rr_q <= ID_DC;
        else        rr_q <= rr_d;
    end
`else
    always_comb begin
        gnt_id = ID_IC;
        if (same_lane)      gnt_id = ID_WR;
        else if (dc_miss_i) gnt_id = ID_DC;
        else if (wr_req_i)  gnt_id = ID_WR;
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dc_data_d   = dc_data_q;
        ic_data_d   = ic_data_q;
        dc_rdy_d    = 1'b0;
        ic_rdy_d    = 1'b0;
        wr_ack_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (req_any) begin
                    gnt_d = gnt_id;
                    if (gnt_id == ID_WR) begin
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = wr_addr_i;
                        mem_wdata_d = wr_data_i;
                        state_d     = ARB_WRITE;
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = (gnt_id == ID_DC) ? dc_lane_addr
                                                       : ic_lane_addr;
                        state_d    = ARB_READ;
                    end
                end
            end
            ARB_READ: begin
                if (mem_ack_i) begin
                    mem_rd_d = 1'b0;
                    state_d  = ARB_RESP;
                    if (gnt_q == ID_DC) begin
                        dc_data_d = mem_data_i;
                        dc_rdy_d  = 1'b1;
                    end else begin
                        ic_data_d = mem_data_i;
                        ic_rdy_d  = 1'b1;
                    end
                end
            end
            ARB_WRITE: begin
                if (mem_ack_i) begin
                    mem_wr_d = 1'b0;
                    wr_ack_d = 1'b1;
                    state_d  = ARB_RESP;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= ID_DC;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dc_rdy_q    <= 1'b0;
            ic_rdy_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            dc_data_q   <= '0;
            ic_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dc_rdy_q    <= dc_rdy_d;
            ic_rdy_q    <= ic_rdy_d;
            wr_ack_q    <= wr_ack_d;
            dc_data_q   <= dc_data_d;
            ic_data_q   <= ic_data_d;
            busy_q      <= busy_d;
        end
    end

    assign dc_data_rdy_o = dc_rdy_q;
    assign dc_data_o     = dc_data_q;
    assign ic_data_rdy_o = ic_rdy_q;
    assign ic_data_o     = ic_data_q;
    assign wr_ack_o      = wr_ack_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_wdata_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed testbench for segre_mem_arbiter.
// Build with SEGRE_MEM_ARB_RR_EN to exercise the round-robin grant order.
module tb_segre_mem_arbiter;

    logic         clk = 1'b0;
    logic         rsn;
    logic         dc_miss;
    logic [31:0]  dc_addr;
    logic         dc_rdy;
    logic [127:0] dc_data;
    logic         ic_miss;
    logic [31:0]  ic_addr;
    logic         ic_rdy;
    logic [127:0] ic_data;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         wr_ack;
    logic         mem_rd;
    logic         mem_wr;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_data;
    logic         busy;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] LANE_A5 = {16{8'hA5}};
    localparam logic [127:0] LANE_3C = {16{8'h3C}};
    localparam logic [127:0] LANE_77 = {16{8'h77}};

    always #5 clk = ~clk;

    segre_mem_arbiter dut (
        .clk_i(clk), .rsn_i(rsn),
        .dc_miss_i(dc_miss), .dc_addr_i(dc_addr),
        .dc_data_rdy_o(dc_rdy), .dc_data_o(dc_data),
        .ic_miss_i(ic_miss), .ic_addr_i(ic_addr),
        .ic_data_rdy_o(ic_rdy), .ic_data_o(ic_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_ack_o(wr_ack),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rsn = 1'b0; dc_miss = 0; ic_miss = 0; wr_req = 0;
        dc_addr = 0; ic_addr = 0; wr_addr = 0; wr_data = 0;
        mem_ack = 0; mem_data = 0;
        tick(); tick();
        rsn = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if ({mem_rd, mem_wr, dc_rdy, ic_rdy, wr_ack} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {mem_rd, mem_wr, dc_rdy, ic_rdy, wr_ack});
        else passed++;
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
            $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_wdata);
        else passed++;
        total++; if (dc_data !== 128'h0 || ic_data !== 128'h0)
            $display("FAIL reset_lanes got %h/%h want 0", dc_data, ic_data);
        else passed++;
        // Stray ack while idle must do nothing.
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
        total++; if ({busy, dc_rdy, ic_rdy, wr_ack} !== 4'b0)
            $display("FAIL idle_ack got %b want 0000", {busy, dc_rdy, ic_rdy, wr_ack});
        else passed++;
    endtask

    task automatic test_dc_single();
        dc_miss = 1'b1; dc_addr = 32'h0000_1234;
        tick();
        total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0)
            $display("FAIL dc_rd_issue got rd=%b wr=%b want 1/0", mem_rd, mem_wr);
        else passed++;
        total++; if (mem_addr !== 32'h0000_1230) $display("FAIL dc_addr got %h want 00001230", mem_addr); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL dc_busy got %b want 1", busy); else passed++;
        tick(); tick(); tick();
        total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_1230)
            $display("FAIL dc_hold got rd=%b addr=%h want 1/00001230", mem_rd, mem_addr);
        else passed++;
        mem_ack = 1'b1; mem_data = LANE_A5;
        tick();
        mem_ack = 1'b0; mem_data = 128'h0;
        total++; if (dc_rdy !== 1'b1) $display("FAIL dc_pulse got %b want 1", dc_rdy); else passed++;
        total++; if (dc_data !== LANE_A5) $display("FAIL dc_lane got %h want %h", dc_data, LANE_A5); else passed++;
        total++; if (ic_rdy !== 1'b0 || wr_ack !== 1'b0 || mem_rd !== 1'b0)
            $display("FAIL dc_others got ic=%b wr=%b rd=%b want 0", ic_rdy, wr_ack, mem_rd);
        else passed++;
        dc_miss = 1'b0;
        tick();
        total++; if (dc_rdy !== 1'b0 || busy !== 1'b0)
            $display("FAIL dc_after got rdy=%b busy=%b want 0/0", dc_rdy, busy);
        else passed++;
        tick();
        total++; if (dc_data !== LANE_A5 || mem_rd !== 1'b0)
            $display("FAIL dc_keep got %h rd=%b want %h/0", dc_data, mem_rd, LANE_A5);
        else passed++;
    endtask

    task automatic test_dc_ic();
        dc_miss = 1'b1; dc_addr = 32'h0000_2008;
        ic_miss = 1'b1; ic_addr = 32'h0000_3004;
        tick();
        total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_2000)
            $display("FAIL dcic_first got rd=%b addr=%h want 1/00002000", mem_rd, mem_addr);
        else passed++;
        mem_ack = 1'b1; mem_data = LANE_3C;
        tick();
        mem_ack = 1'b0;
        total++; if (dc_rdy !== 1'b1 || ic_rdy !== 1'b0)
            $display("FAIL dcic_dc_rdy got dc=%b ic=%b want 1/0", dc_rdy, ic_rdy);
        else passed++;
        dc_miss = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL dcic_gap got busy=%b want 0", busy); else passed++;
        tick();
        total++; if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 32'h0000_3000)
            $display("FAIL dcic_second got busy=%b rd=%b addr=%h want 1/1/00003000", busy, mem_rd, mem_addr);
        else passed++;
        mem_ack = 1'b1; mem_data = LANE_77;
        tick();
        mem_ack = 1'b0; mem_data = 128'h0;
        total++; if (ic_rdy !== 1'b1 || ic_data !== LANE_77 || dc_data !== LANE_3C)
            $display("FAIL dcic_ic got rdy=%b ic=%h dc=%h want 1/%h/%h", ic_rdy, ic_data, dc_data, LANE_77, LANE_3C);
        else passed++;
        ic_miss = 1'b0;
        tick(); tick();
        total++; if (busy !== 1'b0) $display("FAIL dcic_end got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_same_lane();
        wr_req = 1'b1; wr_addr = 32'h0000_0108; wr_data = 32'hDEAD_BEEF;
        dc_miss = 1'b1; dc_addr = 32'h0000_010C;
        tick();
        total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h0000_0108)
            $display("FAIL same_wr got wr=%b rd=%b addr=%h want 1/0/00000108", mem_wr, mem_rd, mem_addr);
        else passed++;
        total++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL same_wdata got %h want deadbeef", mem_wdata); else passed++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (wr_ack !== 1'b1 || dc_rdy !== 1'b0)
            $display("FAIL same_ack got wr=%b dc=%b want 1/0", wr_ack, dc_rdy);
        else passed++;
        wr_req = 1'b0;
        tick(); tick();
        total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0000_0100)
            $display("FAIL same_rd got rd=%b wr=%b addr=%h want 1/0/00000100", mem_rd, mem_wr, mem_addr);
        else passed++;
        mem_ack = 1'b1; mem_data = LANE_A5;
        tick();
        mem_ack = 1'b0;
        total++; if (dc_rdy !== 1'b1 || wr_ack !== 1'b0)
            $display("FAIL same_dc got dc=%b wr=%b want 1/0", dc_rdy, wr_ack);
        else passed++;
        dc_miss = 1'b0;
        tick(); tick();
    endtask

    task automatic test_diff_lane();
        wr_req = 1'b1; wr_addr = 32'h0000_0108; wr_data = 32'hDEAD_BEEF;
        dc_miss = 1'b1; dc_addr = 32'h0000_0200;
        tick();
        total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0000_0200)
            $display("FAIL diff_rd got rd=%b wr=%b addr=%h want 1/0/00000200", mem_rd, mem_wr, mem_addr);
        else passed++;
        mem_ack = 1'b1; mem_data = LANE_3C;
        tick();
        mem_ack = 1'b0;
        total++; if (dc_rdy !== 1'b1 || dc_data !== LANE_3C)
            $display("FAIL diff_dc got rdy=%b lane=%h want 1/%h", dc_rdy, dc_data, LANE_3C);
        else passed++;
        dc_miss = 1'b0;
        tick(); tick();
        total++; if (mem_wr !== 1'b1 || mem_addr !== 32'h0000_0108 || mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL diff_wr got wr=%b addr=%h data=%h want 1/00000108/deadbeef", mem_wr, mem_addr, mem_wdata);
        else passed++;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if (wr_ack !== 1'b1) $display("FAIL diff_ack got %b want 1", wr_ack); else passed++;
        wr_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        dc_miss = 1'b1; dc_addr = 32'h0000_0040;
        tick();
        total++; if (mem_rd !== 1'b1) $display("FAIL rst_pre got rd=%b want 1", mem_rd); else passed++;
        rsn = 1'b0;
        tick();
        rsn = 1'b1; dc_miss = 1'b0;
        total++; if ({busy, mem_rd, mem_wr, dc_rdy, ic_rdy, wr_ack} !== 6'b0)
            $display("FAIL rst_flags got %b want 000000", {busy, mem_rd, mem_wr, dc_rdy, ic_rdy, wr_ack});
        else passed++;
        total++; if (mem_addr !== 32'h0 || dc_data !== 128'h0 || ic_data !== 128'h0)
            $display("FAIL rst_data got addr=%h dc=%h ic=%h want 0", mem_addr, dc_data, ic_data);
        else passed++;
        tick();
        mem_ack = 1'b1; mem_data = LANE_77;
        tick();
        mem_ack = 1'b0; mem_data = 128'h0;
        tick();
        total++; if (dc_rdy !== 1'b0 || busy !== 1'b0 || dc_data !== 128'h0)
            $display("FAIL rst_late got rdy=%b busy=%b lane=%h want 0/0/0", dc_rdy, busy, dc_data);
        else passed++;
    endtask

    // All three held; returns the served requester as 0=DC 1=WR 2=IC 3=none.
    task automatic serve_one(output int who);
        who = 3;
        if (mem_rd && mem_addr == 32'h0000_1000)      who = 0;
        else if (mem_wr && mem_addr == 32'h0000_2004) who = 1;
        else if (mem_rd && mem_addr == 32'h0000_3000) who = 2;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick(); tick();
    endtask

    task automatic test_arbitration();
        int who;
`ifdef SEGRE_MEM_ARB_RR_EN
        int exp_order [4] = '{0, 1, 2, 0};
`else
        int exp_order [4] = '{0, 0, 0, 0};
`endif
        rsn = 1'b0; tick(); rsn = 1'b1;
        dc_miss = 1'b1; dc_addr = 32'h0000_1000;
        wr_req  = 1'b1; wr_addr = 32'h0000_2004; wr_data = 32'h1234_5678;
        ic_miss = 1'b1; ic_addr = 32'h0000_3000;
        tick();
        for (int i = 0; i < 4; i++) begin
            serve_one(who);
            total++; if (who !== exp_order[i])
                $display("FAIL grant_%0d got %0d want %0d", i, who, exp_order[i]);
            else passed++;
        end
        dc_miss = 1'b0;
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick(); tick();
        // DC gone: WR outranks IC in fixed mode; RR may pick either.
        serve_one(who);
`ifndef SEGRE_MEM_ARB_RR_EN
        total++; if (who !== 1) $display("FAIL wr_over_ic got %0d want 1", who); else passed++;
`else
        total++; if (who !== 1 && who !== 2) $display("FAIL rr_tail got %0d want 1 or 2", who); else passed++;
`endif
        wr_req = 1'b0; ic_miss = 1'b0;
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick(); tick();
        total++; if (busy !== 1'b0) $display("FAIL arb_end got busy=%b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_dc_single();
        test_dc_ic();
        test_same_lane();
        test_diff_lane();
        test_reset_mid();
        test_arbitration();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Arbitrates the single main-memory port between three requesters: data-cache lane refills, instruction-cache lane refills, and store-buffer write-through words. It sits between the cache/TL-stage miss logic and the memory model. It serialises one transaction at a time and returns refill lanes with a one-cycle ready pulse. It also enforces write-before-read ordering when a pending store and a data-cache miss target the same lane.

## Interface
- ADDR_SIZE, 32, byte address width
- WORD_SIZE, 32, store data width
- LANE_SIZE, 128, cache lane width in bits; lane offset bits = log2(LANE_SIZE/8)
- clk_i  in  1  clock, all state on rising edge
- rsn_i  in  1  reset, synchronous, active-low
- dc_miss_i  in  1  data-cache refill request, level, held until dc_data_rdy_o
- dc_addr_i  in  ADDR_SIZE  data-cache miss byte address
- dc_data_rdy_o  out  1  one-cycle pulse, refill lane valid
- dc_data_o  out  LANE_SIZE  refill lane
- ic_miss_i  in  1  instruction-cache refill request, level
- ic_addr_i  in  ADDR_SIZE  instruction miss byte address
- ic_data_rdy_o  out  1  one-cycle pulse
- ic_data_o  out  LANE_SIZE  refill lane
- wr_req_i  in  1  store-buffer write-through request, level, held until wr_ack_o
- wr_addr_i  in  ADDR_SIZE  store byte address (not lane-aligned)
- wr_data_i  in  WORD_SIZE  store data
- wr_ack_o  out  1  one-cycle pulse, write committed
- mem_rd_o  out  1  memory read request, held until mem_ack_i
- mem_wr_o  out  1  memory write request, held until mem_ack_i
- mem_addr_o  out  ADDR_SIZE  memory address
- mem_wr_data_o  out  WORD_SIZE  write data
- mem_ack_i  in  1  memory completion; read data valid same cycle
- mem_data_i  in  LANE_SIZE  read lane
- busy_o  out  1  high whenever state != ARB_IDLE

## Operation
- FSM states: ARB_IDLE, ARB_READ, ARB_WRITE, ARB_RESP.
- ARB_IDLE: if any request is high, grant one, latch its id/address/data, go to ARB_READ (dc/ic) or ARB_WRITE (wr). Otherwise stay.
- Read address: mem_addr_o = requester address with the lane-offset bits zeroed. Write address: wr_addr_i unchanged.
- ARB_READ/ARB_WRITE: hold mem_rd_o/mem_wr_o, mem_addr_o, and mem_wr_data_o stable. On mem_ack_i, capture mem_data_i (reads), drop the request, go to ARB_RESP.
- ARB_RESP: pulse exactly one of dc_data_rdy_o, ic_data_rdy_o, wr_ack_o for the granted id, then go to ARB_IDLE.
- dc_data_o/ic_data_o hold the last captured lane until the next refill to that port.
- Fixed priority (default): DC > WR > IC.
- Same-lane override: if wr_req_i and dc_miss_i are both high in ARB_IDLE and wr_addr_i and dc_addr_i agree above the lane-offset bits, WR is granted first. This applies in every configuration.
- Requester contract: a requester drops its request by the ARB_IDLE cycle that follows its ready/ack pulse. The arbiter does not mask a request held longer; it re-serves it.
- mem_ack_i outside ARB_READ/ARB_WRITE is ignored.

## Timing
- All outputs are registered. Reset values: every 1-bit output 0; mem_addr_o, mem_wr_data_o, dc_data_o, ic_data_o all 0; state ARB_IDLE; RR pointer set to DC-highest.
- Request seen in ARB_IDLE at cycle N → mem_rd_o/mem_wr_o high at N+1.
- mem_ack_i at cycle M → ready/ack pulse at M+1 → ARB_IDLE at M+2.
- Minimum turnaround (ack at N+1): pulse at N+2, next grant decision at N+3.
- Requests arriving during a transaction wait; there is no queueing beyond the level inputs.
- Reset mid-transaction: at the reset edge, state goes to ARB_IDLE and all outputs reset. The outstanding memory access is abandoned, and a late mem_ack_i is ignored.

## Configuration
- SEGRE_MEM_ARB_RR_EN defined: round-robin arbitration among DC, WR, IC.
  - After each grant, the granted requester becomes lowest priority. Order starts DC, WR, IC after reset.
  - The same-lane override still takes precedence.
- Not defined: fixed DC > WR > IC. IC may starve under continuous DC/WR traffic; this is accepted.

## Test plan
- DC miss only, dc_addr_i=0x0000_1234, ack 3 cycles after mem_rd_o with mem_data_i=0xA5..A5:
  - mem_addr_o=0x0000_1230.
  - dc_data_rdy_o pulses once, 1 cycle after ack, with dc_data_o=0xA5..A5.
  - ic_data_rdy_o and wr_ack_o stay 0.
- DC and IC miss in the same cycle, fixed priority: DC read completes first, then IC read is issued in the following ARB_IDLE cycle. busy_o drops for exactly 1 cycle between them.
- wr_req_i at 0x0000_0108 (data 0xDEADBEEF) and dc_miss_i at 0x0000_010C together:
  - Write is issued first: mem_wr_o, mem_addr_o=0x108.
  - Then a read is issued at mem_addr_o=0x100.
- Same inputs with dc_addr_i=0x0000_0200: DC read at 0x200 is issued first, then the write at 0x108.
- rsn_i low for 1 cycle while in ARB_READ, then mem_ack_i pulses 2 cycles later:
  - All outputs are 0 after the reset edge.
  - No dc_data_rdy_o pulse; state stays ARB_IDLE.
- SEGRE_MEM_ARB_RR_EN, DC/WR/IC held high at non-conflicting lanes, with each requester re-requesting after service: grant order is DC, WR, IC, DC.
